// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU among N_REQ requesters.
// One operation in flight; result is returned to the owner with valid/ready.
module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 72,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [4*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [3:0]             alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_c,
    output logic                   busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [PW-1:0]    r_rr, r_owner;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_data;
    logic             r_err;

    logic [PW-1:0]    w_win;
    logic             w_any;
    logic [PW:0]      w_idx;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b;
    logic             w_legal;

    // Search upward from the slot after the last owner, wrapping modulo N_REQ.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_rr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N_REQ))
                w_idx = w_idx - (PW+1)'(N_REQ);
            if (!w_any && req_valid[w_idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[PW-1:0];
            end
        end
    end

    assign w_op    = req_op[int'(w_win)*4 +: 4];
    assign w_a     = req_a[int'(w_win)*WIDTH +: WIDTH];
    assign w_b     = req_b[int'(w_win)*WIDTH +: WIDTH];
    assign w_legal = ~w_op[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_legal ? S_EXEC : S_RESP;
            S_EXEC:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (rsp_ready[r_owner]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr    <= PW'(N_REQ - 1);
            r_owner <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        if (w_legal) begin
                            r_op  <= w_op;
                            r_a   <= w_a;
                            r_b   <= w_b;
                            r_cnt <= CW'(ALU_LAT);
                        end else begin
                            // Illegal op: answer immediately, ALU inputs untouched.
                            r_data <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_data <= alu_c;
                        r_err  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_owner]) r_rr <= r_owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (r_state != S_IDLE);
        if (r_state == S_IDLE && w_any && !reset) req_ready[w_win] = 1'b1;
        if (r_state == S_RESP) rsp_valid[r_owner] = 1'b1;
    end

    assign alu_op   = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_data = r_data;
    assign rsp_err  = r_err;

endmodule
